ntt_pointwise_mul: RTL and testbench



---
 rtl/ntt_pointwise_mul.sv | 210 +++++++++++++++++++++
 tb/tb_ntt_pointwise_mul.sv | 345 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ntt_pointwise_mul.sv
// ---------------------------------------------------------------------------
// ntt_pointwise_mul
//
// Streaming pointwise Montgomery multiplier for ML-DSA-65. Sits between the
// forward NTT and the inverse NTT: every accepted input coefficient a[i] is
// multiplied by the matching entry b[i] of an internally buffered NTT-domain
// operand polynomial, and the Montgomery-reduced product
// r = a*b*2^-32 (mod Q), with -Q < r < Q, is streamed out LAT cycles later.
//
// Ports:
//   pwm_clk_i     in   clock, rising edge
//   pwm_rst_i     in   asynchronous active-high reset
//   pwm_clr_i     in   synchronous clear: drop operand buffer, abort stream
//   pwm_bload_i   in   operand-buffer write strobe
//   pwm_bdata_i   in   [W-1:0] signed operand coefficient, |b| < Q
//   pwm_valid_i   in   input coefficient valid (NTT rvalid)
//   pwm_data_i    in   [W-1:0] signed input coefficient, |a| < Q
//   pwm_valid_o   out  product valid, one pulse per product, in index order
//   pwm_data_o    out  [W-1:0] signed product, held while pwm_valid_o=0
//   pwm_bready_o  out  operand buffer holds N coefficients
//   pwm_busy_o    out  a 256-coefficient multiply stream is in progress
//   pwm_err_o     out  sticky protocol-error flag
//
// Control flow: EMPTY -> LOAD (N operand writes) -> READY <-> MUL.
// The operand buffer is kept across MUL -> READY so one operand can be
// applied to many polynomials; only clear or reset invalidates it.
// ---------------------------------------------------------------------------
module ntt_pointwise_mul #(
  parameter int N    = 256,
  parameter int W    = 32,
  parameter int Q    = 8380417,
  parameter int QINV = 58728449,
  parameter int LAT  = 3
) (
  input  logic         pwm_clk_i,
  input  logic         pwm_rst_i,
  input  logic         pwm_clr_i,
  input  logic         pwm_bload_i,
  input  logic [W-1:0] pwm_bdata_i,
  input  logic         pwm_valid_i,
  input  logic [W-1:0] pwm_data_i,
  output logic         pwm_valid_o,
  output logic [W-1:0] pwm_data_o,
  output logic         pwm_bready_o,
  output logic         pwm_busy_o,
  output logic         pwm_err_o
);

  localparam int AW = $clog2(N);
  localparam logic [AW-1:0]         LAST_IDX = AW'(N - 1);
  localparam logic signed [63:0]    Q_S      = 64'(Q);
  localparam logic signed [W-1:0]   QINV_S   = W'(QINV);

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_LOAD  = 2'd1,
    S_READY = 2'd2,
    S_MUL   = 2'd3
  } state_t;

  state_t          state_reg;
  logic [AW-1:0]   load_cnt_reg;
  logic [AW-1:0]   mul_cnt_reg;
  logic            bready_reg;
  logic            busy_reg;
  logic            err_reg;

  // Operand buffer (block RAM): one write port at load_cnt, one registered
  // read port at mul_cnt.
  logic signed [W-1:0] buf_mem [N];
  logic signed [W-1:0] b_rd_reg;

  // Datapath pipeline registers.
  logic [LAT-1:0]      v_pipe_reg;
  logic signed [W-1:0] a_s1_reg;
  logic signed [63:0]  p_s2_reg;
  logic signed [W-1:0] t_s2_reg;
  logic signed [W-1:0] data_reg;

  // Decoded strobes. Clear dominates both bload and valid.
  logic in_fill;     // EMPTY or LOAD: buffer is being (re)filled
  logic in_run;      // READY or MUL: buffer is complete
  logic buf_write;
  logic accept;
  logic proto_err;

  always_comb begin
    in_fill   = (state_reg == S_EMPTY) || (state_reg == S_LOAD);
    in_run    = (state_reg == S_READY) || (state_reg == S_MUL);
    buf_write = pwm_bload_i && !pwm_clr_i && in_fill;
    accept    = pwm_valid_i && !pwm_clr_i && in_run;
    proto_err = !pwm_clr_i &&
                ((pwm_valid_i && in_fill) || (pwm_bload_i && in_run));
  end

  // -------------------------------------------------------------------------
  // Control FSM with registered status outputs.
  // In EMPTY and READY the respective counter is already 0, so the first
  // write/accept uses index 0 without special casing.
  // -------------------------------------------------------------------------
  always_ff @(posedge pwm_clk_i or posedge pwm_rst_i) begin
    if (pwm_rst_i) begin
      state_reg    <= S_EMPTY;
      load_cnt_reg <= '0;
      mul_cnt_reg  <= '0;
      bready_reg   <= 1'b0;
      busy_reg     <= 1'b0;
      err_reg      <= 1'b0;
    end else if (pwm_clr_i) begin
      state_reg    <= S_EMPTY;
      load_cnt_reg <= '0;
      mul_cnt_reg  <= '0;
      bready_reg   <= 1'b0;
      busy_reg     <= 1'b0;
      err_reg      <= 1'b0;
    end else begin
      if (proto_err) begin
        err_reg <= 1'b1;
      end
      case (state_reg)
        S_EMPTY: begin
          if (pwm_bload_i) begin
            load_cnt_reg <= AW'(1);
            state_reg    <= S_LOAD;
          end
        end
        S_LOAD: begin
          if (pwm_bload_i) begin
            // Counter wraps to 0 on the last index, ready for the next fill.
            load_cnt_reg <= load_cnt_reg + AW'(1);
            if (load_cnt_reg == LAST_IDX) begin
              state_reg  <= S_READY;
              bready_reg <= 1'b1;
            end
          end
        end
        S_READY: begin
          if (pwm_valid_i) begin
            mul_cnt_reg <= AW'(1);
            state_reg   <= S_MUL;
            busy_reg    <= 1'b1;
          end
        end
        S_MUL: begin
          if (pwm_valid_i) begin
            mul_cnt_reg <= mul_cnt_reg + AW'(1);
            if (mul_cnt_reg == LAST_IDX) begin
              state_reg <= S_READY;
              busy_reg  <= 1'b0;
            end
          end
        end
        default: begin
          state_reg <= S_EMPTY;
        end
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Operand buffer. No reset: contents are only meaningful once the FSM has
  // seen a full fill, so stale data after reset or clear is never used.
  // The read is free-running at mul_cnt; it lines up with a_s1_reg on the
  // cycle after an accept.
  // -------------------------------------------------------------------------
  always_ff @(posedge pwm_clk_i) begin
    if (buf_write) begin
      buf_mem[load_cnt_reg] <= $signed(pwm_bdata_i);
    end
    b_rd_reg <= buf_mem[mul_cnt_reg];
  end

  // -------------------------------------------------------------------------
  // Three-stage Montgomery datapath.
  //   stage 1: register a alongside the buffer read of b
  //   stage 2: p = a*b (64-bit signed); t = low32(a*b)*QINV (low 32 bits,
  //            computed straight from a and b since only low bits matter)
  //   stage 3: r = (p - t*Q) >>> 32; the low 32 bits of p - t*Q are zero
  //            by construction of t, so the shift is exact.
  // In-flight products keep draining after a clear; only reset kills them.
  // -------------------------------------------------------------------------
  always_ff @(posedge pwm_clk_i or posedge pwm_rst_i) begin
    if (pwm_rst_i) begin
      v_pipe_reg <= '0;
      a_s1_reg   <= '0;
      p_s2_reg   <= '0;
      t_s2_reg   <= '0;
      data_reg   <= '0;
    end else begin
      v_pipe_reg <= {v_pipe_reg[LAT-2:0], accept};
      if (accept) begin
        a_s1_reg <= $signed(pwm_data_i);
      end
      if (v_pipe_reg[0]) begin
        p_s2_reg <= 64'(a_s1_reg) * 64'(b_rd_reg);
        t_s2_reg <= a_s1_reg * b_rd_reg * QINV_S;
      end
      if (v_pipe_reg[1]) begin
        data_reg <= W'((p_s2_reg - 64'(t_s2_reg) * Q_S) >>> 32);
      end
    end
  end

  assign pwm_valid_o  = v_pipe_reg[LAT-1];
  assign pwm_data_o   = data_reg;
  assign pwm_bready_o = bready_reg;
  assign pwm_busy_o   = busy_reg;
  assign pwm_err_o    = err_reg;

endmodule

// File: tb/tb_ntt_pointwise_mul.sv
// ---------------------------------------------------------------------------
// tb_ntt_pointwise_mul
//
// Self-checking bench for ntt_pointwise_mul. A scoreboard queue holds the
// expected residue (mod Q) and the issue cycle of every coefficient the
// bench expects the DUT to accept; a negedge monitor pops one entry per
// output pulse and checks congruence, range and 3-cycle latency.
// Expected residues come from plain modular arithmetic: a*b*2^-32 mod Q,
// with 2^-32 obtained via Fermat (2^(Q-1-32) mod Q).
// ---------------------------------------------------------------------------
module tb_ntt_pointwise_mul;

  localparam longint Q = 8380417;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        clr = 1'b0;
  logic        bload = 1'b0;
  logic [31:0] bdata = '0;
  logic        valid = 1'b0;
  logic [31:0] data_in = '0;
  logic        valid_o;
  logic [31:0] data_o;
  logic        bready;
  logic        busy;
  logic        err;

  ntt_pointwise_mul dut (
    .pwm_clk_i   (clk),
    .pwm_rst_i   (rst),
    .pwm_clr_i   (clr),
    .pwm_bload_i (bload),
    .pwm_bdata_i (bdata),
    .pwm_valid_i (valid),
    .pwm_data_i  (data_in),
    .pwm_valid_o (valid_o),
    .pwm_data_o  (data_o),
    .pwm_bready_o(bready),
    .pwm_busy_o  (busy),
    .pwm_err_o   (err)
  );

  always #5 clk = ~clk;

  int     errors = 0;
  int     checks = 0;
  longint cyc = 0;
  longint rinv;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    longint res;
    longint cin;
  } exp_t;
  exp_t expq[$];

  typedef struct {
    int     a;
    int     b;
    longint exp_res;
  } vec_t;
  vec_t tab[8];

  int     a_vec[256];
  int     b_vec[256];
  longint e_vec[256];

  function automatic longint md(longint x);
    return ((x % Q) + Q) % Q;
  endfunction

  function automatic longint modpow(longint base, longint e);
    longint r = 1;
    longint bb = md(base);
    while (e > 0) begin
      if ((e & 1) != 0) r = (r * bb) % Q;
      bb = (bb * bb) % Q;
      e = e >> 1;
    end
    return r;
  endfunction

  function automatic longint model(longint a, longint b);
    return md(md(md(a) * md(b)) * rinv);
  endfunction

  task automatic chk(input string nm, input longint got, input longint want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, got, want);
    end
  endtask

  // Output monitor.
  exp_t   mon_e;
  longint mon_got;
  always @(negedge clk) begin
    if (valid_o) begin
      checks++;
      if (expq.size() == 0) begin
        errors++;
        $display("FAIL unexpected_pulse: got valid_o=1 data=%0d expected no pulse",
                 $signed(data_o));
      end else begin
        mon_e   = expq.pop_front();
        mon_got = longint'($signed(data_o));
        if (md(mon_got) != mon_e.res || mon_got <= -Q || mon_got >= Q) begin
          errors++;
          $display("FAIL product: got %0d (res %0d) expected res %0d in (-Q,Q)",
                   mon_got, md(mon_got), mon_e.res);
        end
        checks++;
        if (cyc - mon_e.cin != 3) begin
          errors++;
          $display("FAIL latency: got %0d cycles expected 3", cyc - mon_e.cin);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_clr();
    clr = 1'b1;
    tick();
    clr = 1'b0;
  endtask

  task automatic load_b(input int gap);
    for (int i = 0; i < 256; i++) begin
      bload = 1'b1;
      bdata = 32'(b_vec[i]);
      tick();
      bload = 1'b0;
      repeat (gap) tick();
    end
  endtask

  // Streams n coefficients (index i%256). Optional events at a given index:
  // bload pulse (protocol error), clear instead of the coefficient, or an
  // asynchronous reset in mid-cycle.
  task automatic stream(input int n, input int gap, input int bload_at,
                        input int clr_at, input int rst_at);
    for (int i = 0; i < n; i++) begin
      int idx = i % 256;
      if (i == rst_at) begin
        #2 rst = 1'b1;
        #1;
        chk("rst_valid_o", longint'(valid_o), 0);
        chk("rst_data_o", longint'(data_o), 0);
        chk("rst_bready", longint'(bready), 0);
        chk("rst_busy", longint'(busy), 0);
        chk("rst_err", longint'(err), 0);
        expq.delete();
        return;
      end
      if (idx == 128) begin
        chk("busy_mid", longint'(busy), 1);
        chk("bready_mid", longint'(bready), 1);
      end
      valid   = 1'b1;
      data_in = 32'(a_vec[idx]);
      if (i == clr_at) begin
        clr = 1'b1;
        tick();
        clr   = 1'b0;
        valid = 1'b0;
        return;
      end
      if (i == bload_at) begin
        bload = 1'b1;
        bdata = 32'h0012_3456;
      end
      expq.push_back('{res: e_vec[idx], cin: cyc});
      tick();
      bload = 1'b0;
      valid = 1'b0;
      repeat (gap) tick();
    end
  endtask

  task automatic drain();
    int k = 0;
    while (expq.size() != 0 && k < 20) begin
      tick();
      k++;
    end
    chk("drain_left", longint'(expq.size()), 0);
    repeat (4) tick();
  endtask

  task automatic fill_model();
    for (int i = 0; i < 256; i++) e_vec[i] = model(a_vec[i], b_vec[i]);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rinv = modpow(2, Q - 1 - 32);

    // Reset state.
    #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_valid_o", longint'(valid_o), 0);
    chk("reset_data_o", longint'(data_o), 0);
    chk("reset_bready", longint'(bready), 0);
    chk("reset_busy", longint'(busy), 0);
    chk("reset_err", longint'(err), 0);
    rst = 1'b0;
    tick();

    // 1: b = 2^32 mod Q (centred) -> out == a (mod Q).
    for (int i = 0; i < 256; i++) begin
      b_vec[i] = -4186625; a_vec[i] = i; e_vec[i] = i;
    end
    load_b(0);
    chk("t1_bready", longint'(bready), 1);
    chk("t1_busy_idle", longint'(busy), 0);
    stream(256, 0, -1, -1, -1);
    chk("t1_busy_end", longint'(busy), 0);
    drain();

    // 2: b = 0, a = Q-1 -> all outputs 0 (only value in (-Q,Q) that is 0 mod Q).
    do_clr();
    for (int i = 0; i < 256; i++) begin
      b_vec[i] = 0; a_vec[i] = int'(Q - 1); e_vec[i] = 0;
    end
    load_b(0);
    stream(256, 0, -1, -1, -1);
    chk("t2_busy_end", longint'(busy), 0);
    chk("t2_bready_end", longint'(bready), 1);
    drain();

    // 3: two back-to-back polynomials on the same operand, load with gaps.
    do_clr();
    for (int i = 0; i < 256; i++) begin
      b_vec[i] = -4186625;
      a_vec[i] = int'($urandom_range(0, 32'(2 * Q - 2))) - int'(Q - 1);
      e_vec[i] = md(a_vec[i]);
    end
    load_b(1);
    stream(512, 0, -1, -1, -1);
    drain();
    chk("t3_err_clean", longint'(err), 0);

    // 4: gapped valid (1 on, 2 off), (Q-1)*(Q-1) -> 2^-32 mod Q.
    do_clr();
    for (int i = 0; i < 256; i++) begin
      b_vec[i] = int'(Q - 1); a_vec[i] = int'(Q - 1); e_vec[i] = rinv;
    end
    load_b(0);
    stream(256, 2, -1, -1, -1);
    drain();

    // 5: table-driven corner products.
    tab[0] = '{a: int'(Q - 1),    b: int'(Q - 1),    exp_res: 0};
    tab[1] = '{a: -int'(Q - 1),   b: int'(Q - 1),    exp_res: 0};
    tab[2] = '{a: 0,              b: 12345,          exp_res: 0};
    tab[3] = '{a: 1,              b: 1,              exp_res: 0};
    tab[4] = '{a: -1,             b: -1,             exp_res: 0};
    tab[5] = '{a: 4190208,        b: -4190208,       exp_res: 0};
    tab[6] = '{a: -int'(Q - 1),   b: -int'(Q - 1),   exp_res: 0};
    tab[7] = '{a: 1753,           b: -3000000,       exp_res: 0};
    for (int k = 0; k < 8; k++) tab[k].exp_res = model(tab[k].a, tab[k].b);
    do_clr();
    for (int i = 0; i < 256; i++) begin
      a_vec[i] = tab[i % 8].a; b_vec[i] = tab[i % 8].b; e_vec[i] = tab[i % 8].exp_res;
    end
    load_b(0);
    stream(256, 0, -1, -1, -1);
    drain();

    // 6: random operands and inputs against the model.
    do_clr();
    for (int i = 0; i < 256; i++) begin
      b_vec[i] = int'($urandom_range(0, 32'(2 * Q - 2))) - int'(Q - 1);
      a_vec[i] = int'($urandom_range(0, 32'(2 * Q - 2))) - int'(Q - 1);
    end
    fill_model();
    load_b(0);
    stream(256, 1, -1, -1, -1);
    drain();

    // 7: protocol errors. valid in EMPTY -> err, no output pulses.
    do_clr();
    valid = 1'b1; data_in = 32'd7;
    repeat (3) tick();
    valid = 1'b0;
    repeat (5) tick();
    chk("t7_err_empty", longint'(err), 1);
    chk("t7_bready_empty", longint'(bready), 0);
    do_clr();
    chk("t7_err_clr", longint'(err), 0);
    load_b(0);
    chk("t7_err_after_load", longint'(err), 0);
    stream(256, 0, 50, -1, -1);
    drain();
    chk("t7_err_bload_mul", longint'(err), 1);
    // Same operand again: the bload during MUL must not have corrupted it.
    stream(256, 0, -1, -1, -1);
    drain();
    chk("t7_err_sticky", longint'(err), 1);
    do_clr();
    chk("t7_err_cleared", longint'(err), 0);
    chk("t7_bready_cleared", longint'(bready), 0);
    chk("t7_busy_cleared", longint'(busy), 0);

    // 8: clear mid-stream, with a valid on the clear cycle; in-flight drain.
    load_b(0);
    stream(20, 0, -1, 10, -1);
    chk("t8_busy_after_clr", longint'(busy), 0);
    chk("t8_bready_after_clr", longint'(bready), 0);
    drain();
    chk("t8_err_after_clr", longint'(err), 0);

    // 9: asynchronous reset at mul index 100.
    load_b(0);
    stream(256, 0, -1, -1, 100);
    tick();
    rst = 1'b0;
    tick();
    chk("t9_bready_post", longint'(bready), 0);
    chk("t9_busy_post", longint'(busy), 0);
    chk("t9_err_post", longint'(err), 0);
    valid = 1'b1; data_in = 32'd3;
    tick();
    valid = 1'b0;
    repeat (6) tick();
    chk("t9_err_valid_empty", longint'(err), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
